// File: rtl/dpp_table.sv
// dpp_table: fork arbiter for N_PHILO dining philosophers.
// Philosopher events arrive through per-philosopher first-word-fall-through FIFOs.
// A round-robin scan pops at most one event every two cycles. The event is then
// resolved against the fork table: it is granted, queued as hungry, or released.
// A release re-offers the freed forks to the right neighbour, then the left one.
module dpp_table #(
    parameter int unsigned N_PHILO = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_PHILO-1:0] evt_data,
    input  logic [N_PHILO-1:0] evt_empty,
    output logic [N_PHILO-1:0] evt_ack,
    output logic [N_PHILO-1:0] may_eat,
    output logic [N_PHILO-1:0] fork_busy,
    output logic [N_PHILO-1:0] eating,
    output logic               proto_err
);

    localparam int unsigned   PW   = $clog2(N_PHILO);
    localparam logic [PW-1:0] LAST = PW'(N_PHILO - 1);

    typedef enum logic {
        StScan,
        StProc
    } state_e;

    // Registered state
    state_e             r_state;
    logic [PW-1:0]      r_ptr;
    logic               r_evt;      // latched event, 1 = hungry, 0 = done
    logic [N_PHILO-1:0] r_hungry;
    logic [N_PHILO-1:0] r_eating;
    logic [N_PHILO-1:0] r_fork;
    logic [N_PHILO-1:0] r_may_eat;
    logic               r_proto_err;

    // Combinational next-state for the event being processed
    logic [PW-1:0]      w_ptr_r;
    logic [PW-1:0]      w_ptr_l;
    logic [N_PHILO-1:0] w_mask_i;
    logic [N_PHILO-1:0] w_mask_r;
    logic [N_PHILO-1:0] w_mask_l;
    logic [N_PHILO-1:0] w_hungry_d;
    logic [N_PHILO-1:0] w_eating_d;
    logic [N_PHILO-1:0] w_fork_d;
    logic [N_PHILO-1:0] w_grant;
    logic               w_err;
    logic               w_pop;

    function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] dec_mod(input logic [PW-1:0] p);
        return (p == '0) ? LAST : p - PW'(1);
    endfunction

    // Forks used by philosopher p: fork p and fork p+1 (mod N_PHILO).
    function automatic logic [N_PHILO-1:0] fork_mask(input logic [PW-1:0] p);
        logic [N_PHILO-1:0] m;
        logic [PW-1:0]      q;
        q = inc_mod(p);
        for (int unsigned k = 0; k < N_PHILO; k++) begin
            m[k] = (k == 32'(p)) || (k == 32'(q));
        end
        return m;
    endfunction

    assign w_ptr_r  = inc_mod(r_ptr);
    assign w_ptr_l  = dec_mod(r_ptr);
    assign w_mask_i = fork_mask(r_ptr);
    assign w_mask_r = fork_mask(w_ptr_r);
    assign w_mask_l = fork_mask(w_ptr_l);

    // Pop the FIFO under the scan pointer when it holds an event
    assign w_pop = (r_state == StScan) && !evt_empty[r_ptr];

    // Pop strobe, held low during reset even if FIFO 0 is non-empty
    always_comb begin
        evt_ack = '0;
        if (!reset && w_pop) begin
            evt_ack[r_ptr] = 1'b1;
        end
    end

    // Resolve the latched event of philosopher r_ptr against the fork table
    always_comb begin
        w_hungry_d = r_hungry;
        w_eating_d = r_eating;
        w_fork_d   = r_fork;
        w_grant    = '0;
        w_err      = 1'b0;
        if (r_evt) begin
            if (r_eating[r_ptr] || r_hungry[r_ptr]) begin
                w_err = 1'b1;
            end else if ((r_fork & w_mask_i) == '0) begin
                w_fork_d           = r_fork | w_mask_i;
                w_eating_d[r_ptr]  = 1'b1;
                w_grant[r_ptr]     = 1'b1;
            end else begin
                w_hungry_d[r_ptr]  = 1'b1;
            end
        end else if (!r_eating[r_ptr]) begin
            w_err = 1'b1;
        end else begin
            w_eating_d[r_ptr] = 1'b0;
            w_fork_d          = r_fork & ~w_mask_i;
            // Right neighbour has priority on the freed fork i+1
            if (w_hungry_d[w_ptr_r] && ((w_fork_d & w_mask_r) == '0)) begin
                w_fork_d            = w_fork_d | w_mask_r;
                w_eating_d[w_ptr_r] = 1'b1;
                w_hungry_d[w_ptr_r] = 1'b0;
                w_grant[w_ptr_r]    = 1'b1;
            end
            // With two philosophers l == r; the cleared hungry bit blocks a second grant
            if (w_hungry_d[w_ptr_l] && ((w_fork_d & w_mask_l) == '0)) begin
                w_fork_d            = w_fork_d | w_mask_l;
                w_eating_d[w_ptr_l] = 1'b1;
                w_hungry_d[w_ptr_l] = 1'b0;
                w_grant[w_ptr_l]    = 1'b1;
            end
        end
    end

    // Scan/process FSM with registered grant, fork and error outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StScan;
            r_ptr       <= '0;
            r_evt       <= 1'b0;
            r_hungry    <= '0;
            r_eating    <= '0;
            r_fork      <= '0;
            r_may_eat   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_may_eat <= '0;
            case (r_state)
                StScan: begin
                    if (w_pop) begin
                        r_evt   <= evt_data[r_ptr];
                        r_state <= StProc;
                    end else begin
                        r_ptr   <= inc_mod(r_ptr);
                    end
                end
                StProc: begin
                    r_ptr     <= inc_mod(r_ptr);
                    r_state   <= StScan;
                    r_hungry  <= w_hungry_d;
                    r_eating  <= w_eating_d;
                    r_fork    <= w_fork_d;
                    r_may_eat <= w_grant;
                    if (w_err) begin
                        r_proto_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StScan;
                end
            endcase
        end
    end

    assign may_eat   = r_may_eat;
    assign fork_busy = r_fork;
    assign eating    = r_eating;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_dpp_table.sv
// tb_dpp_table: self-checking bench for dpp_table with N_PHILO = 5.
// FIFOs are modelled as queues; a cycle-level reference model tracks who eats,
// who is hungry and where the round-robin scan sits, deriving forks from eaters.
module tb_dpp_table;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] evt_data;
    logic [N-1:0] evt_empty;
    logic [N-1:0] evt_ack;
    logic [N-1:0] may_eat;
    logic [N-1:0] fork_busy;
    logic [N-1:0] eating;
    logic         proto_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit q [N][$];          // pending events per philosopher, 1 = hungry
    int ack_cnt [N];
    int may_cnt [N];
    logic [N-1:0] last_grant;

    // Reference model state
    bit           m_hungry [N];
    bit           m_eating [N];
    bit           m_err;
    int           m_ptr;
    bit           m_proc;
    bit           m_evt;
    logic [N-1:0] m_grant;

    dpp_table #(.N_PHILO(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .evt_data  (evt_data),
        .evt_empty (evt_empty),
        .evt_ack   (evt_ack),
        .may_eat   (may_eat),
        .fork_busy (fork_busy),
        .eating    (eating),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit fork_free(int f);
        for (int p = 0; p < N; p++) begin
            if (m_eating[p] && (f == p || f == (p + 1) % N)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] m_eat_vec();
        logic [N-1:0] v;
        for (int p = 0; p < N; p++) v[p] = m_eating[p];
        return v;
    endfunction

    function automatic logic [N-1:0] m_fork_vec();
        logic [N-1:0] v;
        for (int f = 0; f < N; f++) v[f] = !fork_free(f);
        return v;
    endfunction

    task automatic drive_fifos();
        for (int k = 0; k < N; k++) begin
            evt_empty[k] = (q[k].size() == 0);
            evt_data[k]  = (q[k].size() == 0) ? 1'b0 : q[k][0];
        end
    endtask

    task automatic push(int k, bit h);
        q[k].push_back(h);
        drive_fifos();
    endtask

    task automatic model_clear();
        for (int p = 0; p < N; p++) begin
            m_hungry[p] = 0;
            m_eating[p] = 0;
            ack_cnt[p]  = 0;
            may_cnt[p]  = 0;
        end
        m_err      = 0;
        m_ptr      = 0;
        m_proc     = 0;
        last_grant = '0;
    endtask

    task automatic try_grant(int j);
        if (m_hungry[j] && fork_free(j) && fork_free((j + 1) % N)) begin
            m_hungry[j] = 0;
            m_eating[j] = 1;
            m_grant[j]  = 1'b1;
        end
    endtask

    // Resolve one event of philosopher i following the arbitration rules
    task automatic m_process(int i);
        if (m_evt) begin
            if (m_eating[i] || m_hungry[i]) m_err = 1;
            else if (fork_free(i) && fork_free((i + 1) % N)) begin
                m_eating[i] = 1;
                m_grant[i]  = 1'b1;
            end else m_hungry[i] = 1;
        end else begin
            if (!m_eating[i]) m_err = 1;
            else begin
                m_eating[i] = 0;
                try_grant((i + 1) % N);
                try_grant((i + N - 1) % N);
            end
        end
    endtask

    // One clock: predict ack, let the FIFO pop on the DUT's ack, compare outputs
    task automatic cycle();
        logic [N-1:0] exp_ack;
        logic [N-1:0] ack_obs;
        logic [N-1:0] u;
        #1;
        ack_obs = evt_ack;
        exp_ack = '0;
        m_grant = '0;
        if (!m_proc) begin
            if (q[m_ptr].size() != 0) begin
                exp_ack[m_ptr] = 1'b1;
                m_evt  = q[m_ptr][0];
                m_proc = 1;
            end else m_ptr = (m_ptr + 1) % N;
        end else begin
            m_process(m_ptr);
            m_ptr  = (m_ptr + 1) % N;
            m_proc = 0;
        end
        n_cmp++;
        if (ack_obs !== exp_ack) begin
            n_err++;
            $display("FAIL evt_ack cyc %0d: got %b want %b", cyc, ack_obs, exp_ack);
        end
        for (int k = 0; k < N; k++) begin
            if (ack_obs[k] === 1'b1) begin
                ack_cnt[k]++;
                if (q[k].size() != 0) q[k].delete(0);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        drive_fifos();
        #1;
        for (int k = 0; k < N; k++) if (may_eat[k] === 1'b1) may_cnt[k]++;
        if (may_eat !== '0) last_grant = may_eat;
        n_cmp++;
        if (may_eat !== m_grant) begin
            n_err++;
            $display("FAIL may_eat cyc %0d: got %b want %b", cyc, may_eat, m_grant);
        end
        n_cmp++;
        if (eating !== m_eat_vec()) begin
            n_err++;
            $display("FAIL eating cyc %0d: got %b want %b", cyc, eating, m_eat_vec());
        end
        n_cmp++;
        if (fork_busy !== m_fork_vec()) begin
            n_err++;
            $display("FAIL fork_busy cyc %0d: got %b want %b", cyc, fork_busy, m_fork_vec());
        end
        n_cmp++;
        if (proto_err !== m_err) begin
            n_err++;
            $display("FAIL proto_err cyc %0d: got %b want %b", cyc, proto_err, m_err);
        end
        // Structural invariants read straight off the outputs
        u = '0;
        for (int p = 0; p < N; p++) begin
            if (eating[p] === 1'b1) begin
                u[p] = 1'b1;
                u[(p + 1) % N] = 1'b1;
            end
        end
        n_cmp++;
        if (fork_busy !== u) begin
            n_err++;
            $display("FAIL fork_union cyc %0d: got %b want %b", cyc, fork_busy, u);
        end
        for (int p = 0; p < N; p++) begin
            if (eating[p] === 1'b1 && eating[(p + 1) % N] === 1'b1) begin
                n_err++;
                $display("FAIL adjacent cyc %0d: got eating=%b want no neighbours %0d,%0d",
                         cyc, eating, p, (p + 1) % N);
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int k = 0; k < N; k++) q[k].delete();
        drive_fifos();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
    endtask

    task automatic test_reset();
        int acks;
        reset = 1'b0;
        for (int k = 0; k < N; k++) q[k].delete();
        push(0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({evt_ack, may_eat, fork_busy, eating, proto_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%b may=%b fork=%b eat=%b err=%b want all 0",
                     evt_ack, may_eat, fork_busy, eating, proto_err);
        end
        do_reset();
        // All FIFOs empty for 20 cycles: nothing popped, nothing granted
        run(20);
        acks = 0;
        for (int k = 0; k < N; k++) acks += ack_cnt[k] + may_cnt[k];
        n_cmp++;
        if (acks != 0) begin
            n_err++;
            $display("FAIL idle_activity: got %0d ack/grant pulses want 0", acks);
        end
    endtask

    task automatic test_single_hungry();
        do_reset();
        push(2, 1'b1);
        run(12);
        n_cmp++;
        if (ack_cnt[2] != 1 || may_cnt[2] != 1) begin
            n_err++;
            $display("FAIL single_pulses: got ack=%0d may=%0d want 1/1", ack_cnt[2], may_cnt[2]);
        end
        n_cmp++;
        if (fork_busy !== 5'b01100 || eating !== 5'b00100) begin
            n_err++;
            $display("FAIL single_state: got fork=%b eat=%b want 01100/00100", fork_busy, eating);
        end
    endtask

    task automatic test_neighbor_wait();
        do_reset();
        push(2, 1'b1);
        run(12);
        push(3, 1'b1);
        run(12);
        n_cmp++;
        if (may_cnt[3] != 0 || eating !== 5'b00100) begin
            n_err++;
            $display("FAIL blocked_right: got may3=%0d eat=%b want 0/00100", may_cnt[3], eating);
        end
        push(2, 1'b0);
        run(12);
        n_cmp++;
        if (may_cnt[3] != 1 || fork_busy !== 5'b11000 || eating !== 5'b01000) begin
            n_err++;
            $display("FAIL handoff_right: got may3=%0d fork=%b eat=%b want 1/11000/01000",
                     may_cnt[3], fork_busy, eating);
        end
    endtask

    task automatic test_both_neighbors();
        do_reset();
        push(2, 1'b1);
        run(12);
        push(1, 1'b1);
        push(3, 1'b1);
        run(14);
        n_cmp++;
        if (eating !== 5'b00100 || may_cnt[1] != 0 || may_cnt[3] != 0) begin
            n_err++;
            $display("FAIL both_wait: got eat=%b may1=%0d may3=%0d want 00100/0/0",
                     eating, may_cnt[1], may_cnt[3]);
        end
        push(2, 1'b0);
        run(12);
        n_cmp++;
        if (eating !== 5'b01010 || fork_busy !== 5'b11110 || last_grant !== 5'b01010) begin
            n_err++;
            $display("FAIL both_grant: got eat=%b fork=%b grant=%b want 01010/11110/01010",
                     eating, fork_busy, last_grant);
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        push(0, 1'b1);
        run(10);
        push(4, 1'b0);
        run(12);
        n_cmp++;
        if (proto_err !== 1'b1 || eating !== 5'b00001 || fork_busy !== 5'b00011 ||
            q[4].size() != 0 || ack_cnt[4] != 1) begin
            n_err++;
            $display("FAIL done_idle: got err=%b eat=%b fork=%b q4=%0d ack4=%0d want 1/00001/00011/0/1",
                     proto_err, eating, fork_busy, q[4].size(), ack_cnt[4]);
        end
        push(4, 1'b1);
        run(12);
        n_cmp++;
        if (proto_err !== 1'b1 || may_cnt[4] != 0) begin
            n_err++;
            $display("FAIL err_sticky: got err=%b may4=%0d want 1/0", proto_err, may_cnt[4]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(2, 1'b1);
        for (int t = 0; t < 3 * N && ack_cnt[2] == 0; t++) cycle();
        n_cmp++;
        if (ack_cnt[2] == 0) begin
            n_err++;
            $display("FAIL pop_timeout: got no ack for philo 2 want one within %0d cycles", 3 * N);
        end
        // Now in the processing cycle: abort it
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({evt_ack, may_eat, fork_busy, eating, proto_err} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs: got may=%b fork=%b eat=%b want 0", may_eat, fork_busy, eating);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        run(12);
        n_cmp++;
        if (may_cnt[2] != 0 || eating !== '0) begin
            n_err++;
            $display("FAIL abort_nogrant: got may2=%0d eat=%b want 0/00000", may_cnt[2], eating);
        end
        // Philo 0 eating, then reset with hungry events waiting in FIFOs 0 and 3
        push(0, 1'b1);
        for (int t = 0; t < 3 * N && eating[0] !== 1'b1; t++) cycle();
        push(0, 1'b1);
        push(3, 1'b1);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({evt_ack, may_eat, fork_busy, eating, proto_err} !== '0) begin
            n_err++;
            $display("FAIL reset_eating: got ack=%b fork=%b eat=%b want 0", evt_ack, fork_busy, eating);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (evt_ack !== 5'b00001) begin
            n_err++;
            $display("FAIL first_scan: got ack=%b want 00001", evt_ack);
        end
        run(14);
        n_cmp++;
        if (eating !== 5'b01001 || proto_err !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got eat=%b err=%b want 01001/0", eating, proto_err);
        end
    endtask

    task automatic test_random();
        int  k;
        bit  h;
        do_reset();
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, N - 1);
                if (q[k].size() == 0 && !(m_proc && m_ptr == k) && !m_hungry[k]) begin
                    h = !m_eating[k];
                    // Occasional protocol violation in the second half
                    if (t >= 400 && $urandom_range(0, 9) == 0) h = !h;
                    push(k, h);
                end
            end
            cycle();
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) q[k].delete();
        reset = 1'b1;
        drive_fifos();
        model_clear();
        @(negedge clk);
        test_reset();
        test_single_hungry();
        test_neighbor_wait();
        test_both_neighbors();
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dpp_table.md
DPP_TABLE -- requirements
Module: dpp_table

Interface
REQ-001 The block SHALL have parameter N_PHILO, default 5, meaning the number of philosophers and forks; legal range is 2..8.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port evt_data  input  N_PHILO  event bit per philosopher from its first-word-fall-through output FIFO, valid while its evt_empty bit is low; 1=`PHILO_HUNGRY, 0=`PHILO_DONE (dpp.v).
REQ-005 The block SHALL have port evt_empty  input  N_PHILO  per-philosopher output-FIFO empty flag.
REQ-006 The block SHALL have port evt_ack  output  N_PHILO  per-philosopher FIFO pop strobe, one cycle.
REQ-007 The block SHALL have port may_eat  output  N_PHILO  per-philosopher eat grant, one-cycle pulse.
REQ-008 The block SHALL have port fork_busy  output  N_PHILO  bit i set while fork i is held.
REQ-009 The block SHALL have port eating  output  N_PHILO  bit i set from grant to DONE of philosopher i.
REQ-010 The block SHALL have port proto_err  output  1  sticky protocol-error flag.

Function
REQ-011 Philosopher i SHALL use forks i and (i+1) mod N_PHILO; its left neighbour is (i-1) mod N_PHILO and its right neighbour is (i+1) mod N_PHILO.
REQ-012 The block SHALL keep an internal hungry[N_PHILO] register and a scan pointer ptr, and SHALL run a two-state FSM: SCAN and PROC.
REQ-013 In SCAN with evt_empty[ptr]=0: evt_ack[ptr]=1 for exactly that cycle, evt_data[ptr] latched, next state PROC.
REQ-014 In SCAN with evt_empty[ptr]=1: no ack, ptr advances mod N_PHILO, state stays SCAN.
REQ-015 In PROC: ptr advances mod N_PHILO, next state SCAN, so at most one event is popped per 2 cycles and never twice in a row from the same FIFO.
REQ-016 PROC, HUNGRY from philosopher i (not eating, not hungry): if forks i and i+1 are both free, set both fork_busy bits and eating[i] and pulse may_eat[i]; otherwise set hungry[i].
REQ-017 PROC, DONE from philosopher i (eating): clear eating[i] and forks i, i+1; then in the same cycle re-evaluate neighbours.
REQ-018 Right neighbour first: if hungry[r] and fork (r+1) is free after the release, grant r (fork bits, eating[r], clear hungry[r], may_eat[r] pulse).
REQ-019 Left neighbour second: if hungry[l] and fork l is free after the release and after any right-neighbour grant, grant l identically.
REQ-020 When N_PHILO=2, l==r, and the block SHALL grant that philosopher at most once.
REQ-021 All register updates SHALL take effect on the clock edge ending PROC; may_eat SHALL be high during the cycle after PROC.
REQ-022 Protocol violations SHALL set proto_err until reset, and the event SHALL be discarded with no state change: HUNGRY while eating[i] or hungry[i], or DONE while not eating[i].
REQ-023 Invariant: no two adjacent philosophers SHALL have eating bits set simultaneously, and fork_busy SHALL always equal the union of forks of eating philosophers.
REQ-024 A philosopher's FIFO SHALL NOT be popped when evt_empty is high.

Reset
REQ-025 While reset is high: evt_ack=0, may_eat=0, fork_busy=0, eating=0, hungry=0, proto_err=0, ptr=0, state=SCAN.
REQ-026 Reset asserted mid-PROC SHALL abort the event with no grant issued; the first SCAN after deassertion SHALL examine philosopher 0.

Verification
REQ-027 N=5, all FIFOs empty, 20 cycles -> evt_ack=0, may_eat=0, ptr cycles 0..4.
REQ-028 N=5, HUNGRY from philo 2 only -> evt_ack[2] one cycle, may_eat[2] pulse, fork_busy=5'b01100, eating=5'b00100.
REQ-029 Philo 2 eating, HUNGRY from 3 -> no may_eat[3], hungry[3]=1; then DONE from 2 -> may_eat[3] pulse, fork_busy=5'b11000.
REQ-030 Philos 1 and 3 hungry while 2 eats, then DONE from 2 -> right neighbour 3 granted first, 1 granted in the same cycle since fork 1 is free; eating=5'b01010.
REQ-031 DONE from idle philo 4 -> proto_err=1 sticky, fork_busy/eating unchanged, FIFO still popped.
REQ-032 Reset pulse while philo 0 is eating -> all outputs 0 immediately; after release, a pending HUNGRY in FIFO 0 is serviced first.
